// File: rtl/latency_meter.sv
// latency_meter: round-robin trigger/response latency measurement engine.
// Each channel in turn gets a TRIG_LEN-cycle pulse on trig[ch]. The engine then
// counts clk cycles until a synchronised rising edge on resp[ch], or until the
// timeout is reached, and offers the result on a valid/ready port.
//
// Result handshake: result_valid is held high from REPORT entry until the
// cycle in which result_valid and result_ready are both sampled high at a
// rising clk edge. result_ch, result_data and result_timeout do not change
// while result_valid is high. The transfer happens on that edge and
// result_valid is low in the following cycle.
module latency_meter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int TRIG_LEN = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTH-1:0]    period,
  input  logic [WIDTH-1:0]    timeout,
  input  logic [CHANNELS-1:0] resp,
  output logic [CHANNELS-1:0] trig,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [CH_BITS-1:0]  result_ch,
  output logic [WIDTH-1:0]    result_data,
  output logic                result_timeout,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRIG   = 3'd1,
    S_WAIT   = 3'd2,
    S_REPORT = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  // Last count value of the trigger pulse; count doubles as the pulse timer.
  localparam logic [WIDTH-1:0]   TRIG_LAST = WIDTH'(TRIG_LEN - 1);
  localparam logic [CH_BITS-1:0] CH_LAST   = CH_BITS'(CHANNELS - 1);

  state_t state_q;
  state_t state_d;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] sync3_q;
  logic [CHANNELS-1:0] edge_vec;
  logic                sel_edge;

  logic [CH_BITS-1:0]  ch_q;
  logic [WIDTH-1:0]    count_q;
  logic [WIDTH-1:0]    tmo_q;
  logic [WIDTH-1:0]    per_q;
  logic [WIDTH-1:0]    gap_q;
  logic [WIDTH-1:0]    data_q;
  logic                tflag_q;

  logic [WIDTH-1:0]    eff_timeout;
  logic [WIDTH-1:0]    eff_period;

  logic                start_trig;
  logic                count_inc;
  logic                cap_edge;
  logic                cap_tmo;
  logic                handshake;
  logic                gap_inc;

  // Zero values select the documented fallbacks: longest timeout, shortest gap.
  assign eff_timeout = (timeout == '0) ? '1 : timeout;
  assign eff_period  = (period == '0) ? WIDTH'(1) : period;

  // Only the selected channel's edge matters; the other synchronisers keep running.
  assign edge_vec = sync2_q & ~sync3_q;
  assign sel_edge = edge_vec[ch_q];

  // Two-flop synchroniser per channel plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= resp;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d    = state_q;
    start_trig = 1'b0;
    count_inc  = 1'b0;
    cap_edge   = 1'b0;
    cap_tmo    = 1'b0;
    handshake  = 1'b0;
    gap_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_TRIG;
          start_trig = 1'b1;
        end
      end
      S_TRIG, S_WAIT: begin
        // A real edge wins over a timeout that lands in the same cycle.
        if (sel_edge) begin
          cap_edge = 1'b1;
          state_d  = S_REPORT;
        end else if (count_q == tmo_q) begin
          cap_tmo = 1'b1;
          state_d = S_REPORT;
        end else begin
          count_inc = 1'b1;
          if (state_q == S_TRIG && count_q == TRIG_LAST) begin
            state_d = S_WAIT;
          end
        end
      end
      S_REPORT: begin
        if (result_ready) begin
          handshake = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // GAP lasts exactly per_q cycles (per_q is always at least 1 here).
        if (gap_q == per_q - WIDTH'(1)) begin
          if (enable) begin
            state_d    = S_TRIG;
            start_trig = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latency counter; timeout is captured when a trigger starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tmo_q   <= '0;
    end else if (start_trig) begin
      count_q <= '0;
      tmo_q   <= eff_timeout;
    end else if (count_inc && count_q != '1) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  // Result capture at the end of a measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      tflag_q <= 1'b0;
    end else if (cap_edge) begin
      data_q  <= count_q;
      tflag_q <= 1'b0;
    end else if (cap_tmo) begin
      data_q  <= tmo_q;
      tflag_q <= 1'b1;
    end
  end

  // Channel pointer advance and gap timer; period is captured on the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q  <= '0;
      per_q <= '0;
      gap_q <= '0;
    end else if (handshake) begin
      ch_q  <= (ch_q == CH_LAST) ? '0 : ch_q + CH_BITS'(1);
      per_q <= eff_period;
      gap_q <= '0;
    end else if (gap_inc) begin
      gap_q <= gap_q + WIDTH'(1);
    end
  end

  // Output decode from registered state.
  always_comb begin
    trig = '0;
    if (state_q == S_TRIG) begin
      trig[ch_q] = 1'b1;
    end
  end

  assign result_valid   = (state_q == S_REPORT);
  assign result_ch      = ch_q;
  assign result_data    = data_q;
  assign result_timeout = tflag_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;

  // At most one trigger line is ever active.
  a_trig_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(trig));

  // A pending result does not change until it is accepted.
  a_result_stable: assert property (@(posedge clk) disable iff (reset)
    (result_valid && !result_ready) |=> (result_valid && $stable(result_data)
      && $stable(result_ch) && $stable(result_timeout)));

endmodule

// File: tb/tb_latency_meter.sv
// Testbench for latency_meter: directed measurements with hand-computed
// results pushed into an expected queue, and a monitor that pops and compares
// on every result handshake.
module tb_latency_meter;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 32;
  localparam int TRIG_LEN = 4;
  localparam int CH_BITS  = 2;
  localparam int RW       = CH_BITS + 1 + WIDTH;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [WIDTH-1:0]    period;
  logic [WIDTH-1:0]    timeout;
  logic [CHANNELS-1:0] resp;
  logic [CHANNELS-1:0] trig;
  logic                result_valid;
  logic                result_ready;
  logic [CH_BITS-1:0]  result_ch;
  logic [WIDTH-1:0]    result_data;
  logic                result_timeout;
  logic                busy;
  logic [2:0]          dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int last_hs_per = 0;

  logic [RW-1:0] exp_q[$];

  latency_meter #(
    .CHANNELS(CHANNELS),
    .WIDTH(WIDTH),
    .TRIG_LEN(TRIG_LEN),
    .CH_BITS(CH_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .timeout(timeout),
    .resp(resp),
    .trig(trig),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_ch(result_ch),
    .result_data(result_data),
    .result_timeout(result_timeout),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance n cycles; drivers act and sample 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(input int ch, output bit ok);
    int w;
    w = 0;
    while (trig[ch] !== 1'b1 && w < 300) begin
      step(1);
      w++;
    end
    ok = (trig[ch] === 1'b1);
    check("trig_start", trig[ch], 1'b1);
  endtask

  // One measurement: expected result queued, trigger awaited, resp raised in
  // cycle `delay` (trigger rise = cycle 0, -1 = never), pulse length checked.
  task automatic measure(input int ch, input int delay, input bit exp_tmo,
                         input int exp_data, input int exp_len, input bit gap_chk,
                         input bit keep_resp, input bit drop_en);
    bit ok;
    bit other;
    int k;
    int len;
    logic [CHANNELS-1:0] own;
    exp_q.push_back({CH_BITS'(ch), exp_tmo, WIDTH'(exp_data)});
    wait_trig(ch, ok);
    if (!ok) return;
    if (gap_chk) check("gap_len", cyc - last_hs_cyc, last_hs_per + 1);
    if (drop_en) enable = 1'b0;
    own = '0;
    own[ch] = 1'b1;
    k = 0;
    len = 0;
    other = 1'b0;
    while (result_valid !== 1'b1 && k < 400) begin
      if (trig[ch] === 1'b1) len++;
      if ((trig & ~own) != '0) other = 1'b1;
      if (k == delay) resp[ch] = 1'b1;
      step(1);
      k++;
    end
    check("result_seen", result_valid, 1'b1);
    check("trig_len", len, exp_len);
    check("trig_other", other, 1'b0);
    if (!keep_resp) resp[ch] = 1'b0;
    if (result_ready) step(1);
  endtask

  // Scoreboard monitor: compare on each handshake, record its cycle and gap.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (reset === 1'b0 && result_valid === 1'b1 && result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {result_ch, result_timeout, result_data}, '0);
      end else begin
        e = exp_q.pop_front();
        check("result_ch", result_ch, e[RW-1 -: CH_BITS]);
        check("result_timeout", result_timeout, e[WIDTH]);
        check("result_data", result_data, e[WIDTH-1:0]);
      end
      last_hs_cyc = cyc;
      last_hs_per = (period == '0) ? 1 : int'(period);
    end
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    period       = 10;
    timeout      = 100;
    resp         = '0;
    result_ready = 1'b1;

    // Reset state.
    step(3);
    check("rst_trig", trig, '0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ch", result_ch, '0);
    check("rst_data", result_data, '0);
    check("rst_tmo", result_timeout, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Basic edge measurement and a timeout.
    measure(0, 5, 1'b0, 7, 4, 1'b0, 1'b0, 1'b0);
    timeout = 20;
    measure(1, -1, 1'b1, 20, 4, 1'b1, 1'b0, 1'b0);
    timeout = 100;

    // Round robin with increasing delays, channel wrap 3 -> 0.
    measure(2, 3, 1'b0, 5, 4, 1'b1, 1'b0, 1'b0);
    measure(3, 4, 1'b0, 6, 4, 1'b1, 1'b0, 1'b0);
    measure(0, 5, 1'b0, 7, 4, 1'b1, 1'b0, 1'b0);
    measure(1, 6, 1'b0, 8, 4, 1'b1, 1'b0, 1'b0);

    // Back-pressure: result held stable, no triggers while pending.
    result_ready = 1'b0;
    measure(2, 4, 1'b0, 6, 4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1);
      check("hold_valid", result_valid, 1'b1);
      check("hold_ch", result_ch, 2);
      check("hold_data", result_data, 6);
      check("hold_trig", trig, '0);
    end
    step(1);
    result_ready = 1'b1;
    step(1);
    check("valid_drop", result_valid, 1'b0);
    check("gap_state", dbg_state, 3'd4);

    // Early response during TRIG, held high to later produce a stuck timeout.
    timeout = 20;
    measure(3, 1, 1'b0, 3, 4, 1'b1, 1'b1, 1'b0);
    period = 0;
    measure(0, 0, 1'b0, 2, 3, 1'b1, 1'b0, 1'b0);
    period = 10;
    measure(1, 2, 1'b0, 4, 4, 1'b1, 1'b0, 1'b0);
    measure(2, 7, 1'b0, 9, 4, 1'b1, 1'b0, 1'b0);
    measure(3, -1, 1'b1, 20, 4, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of WAIT.
    begin
      bit ok;
      wait_trig(0, ok);
      step(8);
      reset = 1'b1;
      step(1);
      check("mid_rst_trig", trig, '0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_valid", result_valid, 1'b0);
      check("mid_rst_data", result_data, '0);
      check("mid_rst_ch", result_ch, '0);
      check("mid_rst_state", dbg_state, 3'd0);
      step(1);
      reset = 1'b0;
    end
    measure(0, 5, 1'b0, 7, 4, 1'b0, 1'b0, 1'b0);

    // enable dropped mid-measurement: result still reported, then idle.
    measure(1, 4, 1'b0, 6, 4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      check("idle_trig", trig, '0);
      step(1);
    end
    check("idle_busy", busy, 1'b0);
    check("idle_state", dbg_state, 3'd0);

    step(2);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
